// File: rtl/uart_music_seq.sv
// rtl/uart_music_seq.sv - UART byte-pair note store with tick-timed melody playback to a beeper
module uart_music_seq #(
    parameter int CLK_FREQ = 12000000,
    parameter int TICK_CYC = CLK_FREQ / 1000,
    parameter int DEPTH    = 64,
    parameter int TONE_W   = 8,
    parameter int DUR_W    = 8
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       uart_done,
    input  logic [7:0]                 uart_data,
    input  logic                       play_en,
    input  logic                       loop_en,
    input  logic                       clear,
    output logic [TONE_W-1:0]          tone,
    output logic                       tone_en,
    output logic                       playing,
    output logic [$clog2(DEPTH)-1:0]   note_idx,
    output logic [$clog2(DEPTH):0]     note_len,
    output logic                       overflow,
    output logic                       tick
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int EW = TONE_W + DUR_W;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

    state_t              r_state, w_next;
    logic                r_done_d, r_phase, r_overflow;
    logic [TONE_W-1:0]   r_tone_lat, r_tone;
    logic [AW:0]         r_note_len;
    logic [AW-1:0]       r_note_idx, w_idx_next;
    logic [TW-1:0]       r_tick_cnt;
    logic [DUR_W-1:0]    r_dur_cnt;
    logic [EW-1:0]       r_mem [DEPTH];
    logic [EW-1:0]       r_rd_data;
    logic                w_byte_ev, w_full, w_wr, w_tick, w_adv, w_last, w_stop;
    logic [AW:0]         w_idx_inc;
    logic [TONE_W-1:0]   w_rd_tone;
    logic [DUR_W-1:0]    w_rd_dur;

    assign w_byte_ev = uart_done & ~r_done_d;
    assign w_full    = (r_note_len == (AW+1)'(DEPTH));
    assign w_wr      = w_byte_ev & r_phase & ~clear & ~w_full;
    assign w_tick    = (r_tick_cnt == TW'(TICK_CYC - 1));
    assign w_rd_tone = r_rd_data[EW-1:DUR_W];
    assign w_rd_dur  = r_rd_data[DUR_W-1:0];
    assign w_idx_inc = (AW+1)'(r_note_idx) + (AW+1)'(1);
    assign w_last    = (w_idx_inc >= r_note_len);
    assign w_stop    = w_adv & w_last & ~loop_en;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + TW'(1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_done_d   <= 1'b0;
            r_phase    <= 1'b0;
            r_tone_lat <= '0;
            r_note_len <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done_d <= uart_done;
            if (clear) begin
                r_phase    <= 1'b0;
                r_note_len <= '0;
                r_overflow <= 1'b0;
            end else if (w_byte_ev) begin
                r_phase <= ~r_phase;
                if (!r_phase)    r_tone_lat <= TONE_W'(uart_data);
                else if (w_full) r_overflow <= 1'b1;
                else             r_note_len <= r_note_len + (AW+1)'(1);
            end
        end
    end

    // Read address is the next index so the entry is ready in the LOAD cycle.
    always_ff @(posedge sys_clk) begin
        if (w_wr) r_mem[r_note_len[AW-1:0]] <= {r_tone_lat, DUR_W'(uart_data)};
        r_rd_data <= r_mem[w_idx_next];
    end

    always_comb begin
        w_adv = 1'b0;
        case (r_state)
            S_LOAD:  w_adv = (w_rd_dur == '0);
            S_PLAY:  w_adv = w_tick & play_en & (r_dur_cnt == DUR_W'(1));
            default: w_adv = 1'b0;
        endcase
        w_idx_next = r_note_idx;
        if (clear)      w_idx_next = '0;
        else if (w_adv) w_idx_next = w_last ? '0 : w_idx_inc[AW-1:0];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (clear) w_next = S_IDLE;
        else begin
            case (r_state)
                S_IDLE:  if (play_en && r_note_len != '0) w_next = S_LOAD;
                S_LOAD:  w_next = w_adv ? (w_stop ? S_IDLE : S_LOAD) : S_PLAY;
                S_PLAY:  if (w_adv) w_next = w_stop ? S_IDLE : S_LOAD;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        playing = 1'b0;
        tone_en = 1'b0;
        case (r_state)
            S_LOAD:  playing = 1'b1;
            S_PLAY: begin
                playing = 1'b1;
                tone_en = play_en & (r_tone != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_note_idx <= '0;
            r_tone     <= '0;
            r_dur_cnt  <= '0;
        end else begin
            r_note_idx <= w_idx_next;
            if (clear || w_stop)     r_tone <= '0;
            else if (r_state == S_LOAD) r_tone <= w_rd_tone;
            if (r_state == S_LOAD) r_dur_cnt <= w_rd_dur;
            else if (r_state == S_PLAY && w_tick && play_en) r_dur_cnt <= r_dur_cnt - DUR_W'(1);
        end
    end

    assign tone     = r_tone;
    assign note_idx = r_note_idx;
    assign note_len = r_note_len;
    assign overflow = r_overflow;
    assign tick     = w_tick;
endmodule

// File: tb/tb_uart_music_seq.sv
// tb/tb_uart_music_seq.sv - directed self-checking bench for uart_music_seq (DEPTH=4, TICK_CYC=10)
module tb_uart_music_seq;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_done = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       play_en = 1'b0;
    logic       loop_en = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] tone;
    logic       tone_en, playing, overflow, tick;
    logic [1:0] note_idx;
    logic [2:0] note_len;

    int checks = 0;
    int errors = 0;
    int cnt [256];
    int paused_en, held_tone, total, rest;

    uart_music_seq #(.CLK_FREQ(10000), .TICK_CYC(10), .DEPTH(4), .TONE_W(8), .DUR_W(8)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_done(uart_done), .uart_data(uart_data),
        .play_en(play_en), .loop_en(loop_en), .clear(clear), .tone(tone), .tone_en(tone_en),
        .playing(playing), .note_idx(note_idx), .note_len(note_len), .overflow(overflow), .tick(tick)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        uart_data = b;
        uart_done = 1'b1;
        repeat (hold) @(posedge sys_clk);
        #1 uart_done = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge sys_clk);
        #1 clear = 1'b0;
    endtask

    task automatic run_play(input int pause_at, input int pause_len);
        for (int i = 0; i < 256; i++) cnt[i] = 0;
        paused_en = 0; held_tone = 0; total = 0; rest = 0;
        play_en = 1'b1;
        @(posedge sys_clk);
        for (int c = 0; c < 2000; c++) begin
            @(negedge sys_clk);
            if (!playing) break;
            total++;
            if (tone_en) cnt[tone]++;
            if (tone == 8'd0) rest++;
            if (c > pause_at && c <= pause_at + pause_len && tone_en) paused_en++;
            if (c == pause_at) play_en = 1'b0;
            if (c == pause_at + pause_len) begin
                held_tone = int'(tone);
                play_en = 1'b1;
            end
        end
        play_en = 1'b0;
        chk("run_stopped", {31'd0, playing}, 32'd1 - 32'd1);
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int nticks, notplay, switches, last;
        logic stopped, seen;

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_tone", tone, 0);
        chk("rst_tone_en", tone_en, 0);
        chk("rst_playing", playing, 0);
        chk("rst_note_len", note_len, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tick", tick, 0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        nticks = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge sys_clk);
            if (tick) nticks++;
        end
        chk("tick_count_100cyc", nticks, 10);
        @(posedge sys_clk); #1;

        send_byte(8'h05, 1); send_byte(8'h03, 1); send_byte(8'h0A, 1); send_byte(8'h02, 1);
        chk("load_note_len", note_len, 2);
        run_play(-10, 0);
        chk("once_t5_20_40", (cnt[5] >= 20 && cnt[5] <= 40), 1);
        chk("once_t10_10_30", (cnt[10] >= 10 && cnt[10] <= 30), 1);
        chk("once_end_tone", tone, 0);
        chk("once_end_tone_en", tone_en, 0);
        chk("once_end_idx", note_idx, 0);
        chk("once_end_len", note_len, 2);

        loop_en = 1'b1; play_en = 1'b1;
        @(posedge sys_clk);
        notplay = 0; switches = 0; last = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge sys_clk);
            if (!playing) notplay++;
            if (tone_en) begin
                if (last != 0 && int'(tone) != last) switches++;
                last = int'(tone);
            end
        end
        chk("loop_playing_held", notplay, 0);
        chk("loop_switches_ge4", (switches >= 4), 1);
        loop_en = 1'b0;
        stopped = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge sys_clk);
            if (!playing) begin
                stopped = 1'b1;
                play_en = 1'b0;
                break;
            end
        end
        chk("loop_stop", stopped, 1);
        chk("loop_stop_idx", note_idx, 0);
        @(posedge sys_clk); #1;

        run_play(15, 50);
        chk("pause_no_enable", paused_en, 0);
        chk("pause_tone_held", held_tone, 5);
        chk("pause_t5_20_40", (cnt[5] >= 20 && cnt[5] <= 40), 1);
        chk("pause_t10_10_30", (cnt[10] >= 10 && cnt[10] <= 30), 1);

        pulse_clear();
        send_byte(8'h00, 1); send_byte(8'h04, 1);
        send_byte(8'h07, 1); send_byte(8'h00, 1);
        send_byte(8'h05, 1); send_byte(8'h01, 1);
        chk("edge_note_len", note_len, 3);
        run_play(-10, 0);
        chk("skip_t7_never", cnt[7], 0);
        chk("rest_t0_never_en", cnt[0], 0);
        chk("rest_cycles_30_45", (rest >= 30 && rest <= 45), 1);
        chk("edge_t5_1_12", (cnt[5] >= 1 && cnt[5] <= 12), 1);
        chk("edge_total_30_60", (total >= 30 && total <= 60), 1);

        pulse_clear();
        for (int p = 1; p <= 5; p++) begin
            send_byte((p == 5) ? 8'h09 : 8'(p), 1);
            send_byte(8'h01, 1);
        end
        chk("ovf_note_len", note_len, 4);
        chk("ovf_flag", overflow, 1);
        run_play(-10, 0);
        chk("ovf_t9_absent", cnt[9], 0);
        chk("ovf_t4_present", (cnt[4] != 0), 1);
        pulse_clear();
        chk("clr_note_len", note_len, 0);
        chk("clr_overflow", overflow, 0);

        send_byte(8'h05, 1);
        uart_data = 8'h06; uart_done = 1'b1; clear = 1'b1;
        @(posedge sys_clk);
        #1 uart_done = 1'b0; clear = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("clr_pair_lost", note_len, 0);
        send_byte(8'h06, 1); send_byte(8'h02, 1);
        chk("clr_phase_reset", note_len, 1);

        send_byte(8'h08, 100);
        send_byte(8'h01, 1);
        chk("level_one_event", note_len, 2);

        loop_en = 1'b1; play_en = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge sys_clk);
            if (tone_en) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_pre_enabled", seen, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_tone", tone, 0);
        chk("arst_tone_en", tone_en, 0);
        chk("arst_playing", playing, 0);
        chk("arst_note_len", note_len, 0);
        chk("arst_note_idx", note_idx, 0);
        play_en = 1'b0; loop_en = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_music_seq.md
Name: uart_music_seq

Overview:
Parametrised successor to the fixed UART-to-beeper music path. It assembles UART byte pairs (tone, duration) into a note store of DEPTH entries, then plays the stored melody through the Beeper tone/enable interface. It supports play-once and loop modes, pause, clear and overflow flagging. It has its own tick generator, so no external 1 ms divider is needed. It sits between uart_recv and Beeper in top.

Parameters:
CLK_FREQ, 12000000, system clock in Hz (documentation/derivation only)
TICK_CYC, 12000, sys_clk cycles per duration tick (1 ms at 12 MHz)
DEPTH, 64, note-store entries; power of two, >=2
TONE_W, 8, tone code width
DUR_W, 8, duration width in ticks

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
uart_done  in  1  byte-received strobe (pulse or level; rising edge used)
uart_data  in  8  received byte, valid when uart_done rises
play_en  in  1  1 = play/resume, 0 = pause
loop_en  in  1  1 = wrap to entry 0 after last entry, 0 = stop after last
clear  in  1  synchronous clear of store and playback
tone  out  TONE_W  current tone code to Beeper
tone_en  out  1  Beeper enable
playing  out  1  FSM in LOAD or PLAY
note_idx  out  log2(DEPTH)  index of entry being played
note_len  out  log2(DEPTH)+1  number of stored entries
overflow  out  1  sticky: a pair was dropped because the store was full
tick  out  1  one-cycle pulse every TICK_CYC cycles

Behaviour:
- Reset (async, sys_rst_n=0): all outputs 0; pointers, counters, byte-phase and edge-detect registers 0; FSM IDLE.
- Edge detect: uart_done registered once; the byte event fires on a 0->1 transition. Byte latency to store write is <=2 cycles.
- Byte assembly:
  - Phase 0: the byte is latched as tone (low TONE_W bits, zero-extended).
  - Phase 1: the byte is duration; the pair is written at address note_len and note_len increments.
  - Phase toggles on each byte event.
- Full: if note_len==DEPTH when a pair completes, the pair is discarded and overflow is set. The phase still toggles.
- Store: synchronous-read RAM, one write port and one read port. Read data is valid one cycle after the address.
- Tick counter: free-running 0..TICK_CYC-1; tick=1 in the cycle the counter equals TICK_CYC-1.
- FSM:
  - IDLE: tone_en=0. Goes to LOAD when play_en=1 and note_len!=0, with read address = note_idx.
  - LOAD (1 cycle): tone <= entry.tone; dur_cnt <= entry.dur. If entry.dur==0 the entry is skipped: advance, and do not enter PLAY. Otherwise go to PLAY.
  - PLAY:
    - tone_en = play_en & (tone!=0); tone code 0 is a rest.
    - On tick with play_en=1, dur_cnt decrements. When dur_cnt reaches 0, advance.
    - play_en=0 freezes dur_cnt and holds state (pause). tone keeps its value.
  - Advance: if note_idx+1 < note_len, note_idx++ and go to LOAD. Otherwise:
    - loop_en=1: note_idx=0 and go to LOAD.
    - loop_en=0: note_idx=0, go to IDLE, tone=0.
- An entry of duration D plays for D ticks (±1 tick of phase uncertainty at start).
- Appending while playing is legal. New entries are reached if they are written before the advance check.
- clear=1: note_len=0, note_idx=0, phase=0, FSM to IDLE, tone=0, tone_en=0, overflow=0. Clear has priority over a simultaneous pair write; that pair is lost. Tick is unaffected.
- Reset mid-note: everything returns to reset values and stored data is considered invalid (note_len=0).
- loop_en is sampled only at the advance point.

Test Plan:
- TICK_CYC=10. Send bytes 0x05,0x03,0x0A,0x02, then play_en=1, loop_en=0 -> tone=5 with tone_en=1 for 30 cycles (±10), then tone=10 for 20 cycles, then IDLE with tone_en=0, note_len=2, note_idx=0.
- Same data with loop_en=1 -> the sequence 5,10,5,10... repeats; playing stays 1. Set loop_en=0 mid-entry 1 -> playback stops after that pass.
- Pause: drop play_en for 50 cycles mid-note -> tone_en=0, dur_cnt frozen. On resume the remaining ticks complete; total tone=5 time is 30 enable cycles.
- Edge cases: entry (0x00,0x04) -> tone_en=0 for 4 ticks (rest). Entry (0x07,0x00) -> skipped; tone 7 is never enabled.
- DEPTH=4: send 5 pairs -> note_len=4, overflow=1, 5th pair absent. Then clear -> note_len=0, overflow=0.
- Edge cases: assert sys_rst_n=0 mid-PLAY -> all outputs 0 asynchronously. Clear in the same cycle as the 2nd byte of a pair -> note_len stays 0. A uart_done level held high for 100 cycles -> exactly one byte event.
